regfile_exec_seq: RTL and testbench

//  Execute sequencer that sits directly upstream of the 8x16 general-purpose register file.
//  It accepts 16-bit instructions over a valid/ready handshake and performs each one in steps:
//    - reads operands one at a time over the file's single read port (SRC -> D_OUT);
//    - computes a 16-bit ALU result;
//    - writes the result back (DST/D_IN/STO).

---
 rtl/regfile_exec_seq.sv | 204 ++++++++++++++++++++
 tb/tb_regfile_exec_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_exec_seq.sv
// Execute sequencer in front of an 8x16 single-read-port register file.
// Reads operands one per cycle, computes a 16-bit ALU result and writes it back.
module regfile_exec_seq #(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit LDI_SIGN_EXT   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_instr,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  input  logic        i_clr_req,
  output logic [15:0] o_rf_src,
  output logic [15:0] o_rf_dst,
  output logic [15:0] o_rf_din,
  output logic        o_rf_sto,
  output logic        o_rf_rst,
  input  logic [15:0] i_rf_dout,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_flag_z,
  output logic        o_flag_c
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_READ_A, S_READ_B, S_WRITE} state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_MOV = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8, OP_SHR = 4'h9, OP_LDI = 4'hA;

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [3:0]  r_op;
  logic [2:0]  r_rd;
  logic [2:0]  r_rb;
  logic [15:0] r_opa;
  logic        r_idle;
  logic [15:0] r_src;
  logic [15:0] r_dst;
  logic [15:0] r_din;
  logic        r_sto;
  logic        r_rst;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_z;
  logic        r_c;

  logic        w_accept;
  logic        w_to_write;
  logic [3:0]  w_in_op;
  logic [3:0]  w_alu_op;
  logic [2:0]  w_rd;
  logic [15:0] w_alu_a;
  logic [16:0] w_alu;

  function automatic logic is_two_input(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  function automatic logic is_one_input(input logic [3:0] op);
    return (op == OP_MOV) || (op == OP_NOT) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

  assign o_instr_ready = r_idle & ~i_clr_req;
  assign w_accept      = i_instr_valid & o_instr_ready;
  assign w_in_op       = i_instr[15:12];

  // The ALU is fed from whichever cycle is about to present the write.
  assign w_alu_op = (r_state == S_IDLE) ? w_in_op : r_op;
  assign w_rd     = (r_state == S_IDLE) ? i_instr[11:9] : r_rd;
  assign w_alu_a  = (r_state == S_READ_B) ? r_opa : i_rf_dout;

  assign w_to_write = ((r_state == S_IDLE) && w_accept && (w_in_op == OP_LDI)) ||
                      ((r_state == S_READ_A) && !is_two_input(r_op)) ||
                      (r_state == S_READ_B);

  always_comb begin
    w_alu = '0;
    case (w_alu_op)
      OP_MOV: w_alu = {1'b0, w_alu_a};
      OP_ADD: w_alu = {1'b0, w_alu_a} + {1'b0, i_rf_dout};
      OP_SUB: w_alu = {1'b0, w_alu_a} - {1'b0, i_rf_dout};
      OP_AND: w_alu = {1'b0, w_alu_a & i_rf_dout};
      OP_OR:  w_alu = {1'b0, w_alu_a | i_rf_dout};
      OP_XOR: w_alu = {1'b0, w_alu_a ^ i_rf_dout};
      OP_NOT: w_alu = {1'b0, ~w_alu_a};
      OP_SHL: w_alu = {w_alu_a[15], w_alu_a[14:0], 1'b0};
      OP_SHR: w_alu = {w_alu_a[0], 1'b0, w_alu_a[15:1]};
      OP_LDI: w_alu = {1'b0, LDI_SIGN_EXT ? {{7{i_instr[8]}}, i_instr[8:0]}
                                          : {7'b0, i_instr[8:0]}};
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      r_idx   <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_rb    <= '0;
      r_opa   <= '0;
      r_idle  <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_din   <= '0;
      r_sto   <= 1'b0;
      r_rst   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
    end else begin
      // Strobes and buses return to 0 unless the next state drives them.
      r_sto  <= 1'b0;
      r_rst  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_src  <= '0;
      r_dst  <= '0;
      r_din  <= '0;
      r_idle <= 1'b0;
      r_busy <= 1'b1;
      case (r_state)
        S_CLEAR: begin
          if (r_idx[3]) begin
            r_state <= S_IDLE;
            r_idle  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_rst <= 1'b1;
            r_dst <= {10'b0, r_idx[2:0], 3'b0};
            r_idx <= r_idx + 4'd1;
          end
        end
        S_IDLE: begin
          r_idle <= 1'b1;
          r_busy <= 1'b0;
          if (i_clr_req) begin
            // Entry index 0 is presented right away, so the sweep resumes at 1.
            r_state <= S_CLEAR;
            r_rst   <= 1'b1;
            r_idx   <= 4'd1;
            r_idle  <= 1'b0;
            r_busy  <= 1'b1;
          end else if (w_accept) begin
            r_op <= w_in_op;
            r_rd <= i_instr[11:9];
            r_rb <= i_instr[5:3];
            if (is_two_input(w_in_op) || is_one_input(w_in_op)) begin
              r_state <= S_READ_A;
              r_src   <= {10'b0, i_instr[8:6], 3'b0};
              r_idle  <= 1'b0;
              r_busy  <= 1'b1;
            end else if (w_in_op != OP_LDI) begin
              r_done <= 1'b1;
              r_err  <= (w_in_op != OP_NOP);
            end
          end
        end
        S_READ_A: begin
          r_opa <= i_rf_dout;
          if (is_two_input(r_op)) begin
            r_state <= S_READ_B;
            r_src   <= {10'b0, r_rb, 3'b0};
          end
        end
        S_READ_B: begin
        end
        S_WRITE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          r_idle  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_to_write) begin
        r_state <= S_WRITE;
        r_sto   <= 1'b1;
        r_dst   <= {10'b0, w_rd, 3'b0};
        r_din   <= w_alu[15:0];
        r_z     <= (w_alu[15:0] == 16'h0000);
        r_c     <= w_alu[16];
        r_idle  <= 1'b0;
        r_busy  <= 1'b1;
      end
    end
  end

  assign o_rf_src = r_src;
  assign o_rf_dst = r_dst;
  assign o_rf_din = r_din;
  assign o_rf_sto = r_sto;
  assign o_rf_rst = r_rst;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_flag_z = r_z;
  assign o_flag_c = r_c;

endmodule

// File: tb/tb_regfile_exec_seq.sv
// Bench for regfile_exec_seq: a behavioural register file plus an instruction-level
// reference model that predicts write data, flags, timing and the clear sweep.
module tb_regfile_exec_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        valid = 1'b0;
  logic        clr_req = 1'b0;
  logic        ready;
  logic [15:0] src;
  logic [15:0] dst;
  logic [15:0] din;
  logic        sto;
  logic        rf_rst;
  logic [15:0] dout;
  logic        busy;
  logic        done;
  logic        err;
  logic        fz;
  logic        fc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_exec_seq dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_instr      (instr),
    .i_instr_valid(valid),
    .o_instr_ready(ready),
    .i_clr_req    (clr_req),
    .o_rf_src     (src),
    .o_rf_dst     (dst),
    .o_rf_din     (din),
    .o_rf_sto     (sto),
    .o_rf_rst     (rf_rst),
    .i_rf_dout    (dout),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_flag_z     (fz),
    .o_flag_c     (fc)
  );

  // Register file the sequencer drives; scrambled while reset is held.
  logic [15:0] rf [8];
  assign dout = rf[src[5:3]];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'($urandom);
    end else if (sto) begin
      rf[dst[5:3]] <= din;
    end else if (rf_rst) begin
      rf[dst[5:3]] <= '0;
    end
  end

  // Reference model state
  logic [15:0] mdl [8];
  logic        mz = 1'b0;
  logic        mc = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mdl[i] = '0;
  endtask

  // Called on a negedge; expects the sweep to start within a few cycles.
  task automatic check_sweep(input string who);
    for (int w = 0; w < 4 && !rf_rst; w++) @(negedge clk);
    check({who, "_sweep_start"}, 32'(rf_rst), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check({who, "_sweep_rst"}, 32'(rf_rst), 32'd1);
      check({who, "_sweep_idx"}, 32'(dst), 32'(i * 8));
      check({who, "_sweep_quiet"}, {29'b0, sto, done, ready}, 32'd0);
      @(negedge clk);
    end
    check({who, "_sweep_end_ready"}, 32'(ready), 32'd1);
    check({who, "_sweep_end_rst"}, 32'(rf_rst), 32'd0);
    check({who, "_sweep_end_busy"}, 32'(busy), 32'd0);
    check({who, "_sweep_end_done"}, 32'(done), 32'd0);
    model_clear();
    for (int i = 0; i < 8; i++) check({who, "_cleared_reg"}, 32'(rf[i]), 32'd0);
  endtask

  // Called on a negedge with the sequencer idle; returns on the negedge showing DONE.
  task automatic run_instr(input logic [15:0] ins);
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] a, b, res;
    logic        c, writes, illegal;
    int unsigned sum;
    int          lat, sto_cyc, done_cyc;
    logic [15:0] got_din;
    logic [2:0]  got_rd;
    logic        got_err;
    op = ins[15:12];
    rd = ins[11:9];
    a = mdl[ins[8:6]];
    b = mdl[ins[5:3]];
    res = '0; c = 1'b0; writes = 1'b1; illegal = 1'b0; lat = 2;
    case (op)
      4'h1: res = a;
      4'h2: begin sum = 32'(a) + 32'(b); res = sum[15:0]; c = (sum > 32'hFFFF); lat = 3; end
      4'h3: begin res = a - b; c = (a < b); lat = 3; end
      4'h4: begin res = a & b; lat = 3; end
      4'h5: begin res = a | b; lat = 3; end
      4'h6: begin res = a ^ b; lat = 3; end
      4'h7: res = ~a;
      4'h8: begin res = a << 1; c = a[15]; end
      4'h9: begin res = a >> 1; c = a[0]; end
      4'hA: begin res = {7'b0, ins[8:0]}; lat = 1; end
      4'h0: writes = 1'b0;
      default: begin writes = 1'b0; illegal = 1'b1; end
    endcase
    instr = ins;
    valid = 1'b1;
    check("ready_before_accept", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    instr = 16'($urandom);
    sto_cyc = 0; done_cyc = 0; got_din = '0; got_rd = '0; got_err = 1'b0;
    for (int n = 1; n <= 10 && done_cyc == 0; n++) begin
      @(negedge clk);
      if (sto) begin
        sto_cyc = (sto_cyc == 0) ? n : 99;
        got_din = din;
        got_rd = dst[5:3];
      end
      if (done) begin
        done_cyc = n;
        got_err = err;
      end
    end
    if (writes) begin
      check("sto_latency", 32'(sto_cyc), 32'(lat));
      check("din", 32'(got_din), 32'(res));
      check("dst", 32'(got_rd), 32'(rd));
      check("done_latency", 32'(done_cyc), 32'(lat + 1));
      check("err_on_legal", 32'(got_err), 32'd0);
      mdl[rd] = res;
      mz = (res == 16'h0000);
      mc = c;
    end else begin
      check("no_sto", 32'(sto_cyc), 32'd0);
      check("done_latency_nowrite", 32'(done_cyc), 32'd1);
      check("err_flag", 32'(got_err), 32'(illegal));
    end
    check("flag_z", 32'(fz), 32'(mz));
    check("flag_c", 32'(fc), 32'(mc));
    $display("instr %h op %h rd %0d: din %h sto@%0d done@%0d err %0d z %0d c %0d",
             ins, op, rd, got_din, sto_cyc, done_cyc, got_err, fz, fc);
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input int rd, input int ra, input int rb);
    return {op, 3'(rd), 3'(ra), 3'(rb), 3'b000};
  endfunction

  function automatic logic [15:0] enc_ldi(input int rd, input logic [8:0] imm);
    return {4'hA, 3'(rd), imm};
  endfunction

  initial begin
    logic [3:0] rop;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_strobes", {30'b0, sto, rf_rst}, 32'd0);
    check("rst_busy_done", {30'b0, busy, done}, 32'd0);
    check("rst_flags", {30'b0, fz, fc}, 32'd0);
    rst_n = 1'b1;
    check_sweep("por");

    // Directed operand corner cases
    run_instr(enc_ldi(1, 9'h000));
    run_instr(enc(4'h7, 1, 1, 0));          // r1 = 0xFFFF
    run_instr(enc_ldi(2, 9'h001));
    run_instr(enc(4'h2, 3, 1, 2));          // 0xFFFF + 1: Z=1, C=1
    run_instr(enc(4'h3, 4, 2, 1));          // 1 - 0xFFFF: 0x0002, C=1
    run_instr(enc(4'h9, 6, 2, 0));          // SHR 1: 0, C=1
    run_instr(enc(4'h8, 7, 1, 0));          // SHL 0xFFFF: C=1
    run_instr(enc_ldi(5, 9'h1FF));
    run_instr(16'hC123);                    // illegal: flags held
    run_instr(16'h0ABC);                    // NOP
    run_instr(enc(4'h2, 2, 2, 2));          // rd == ra == rb

    // CLR_REQ beats a simultaneous instruction
    instr = enc_ldi(0, 9'h055);
    valid = 1'b1;
    clr_req = 1'b1;
    #1;
    check("clr_blocks_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    check_sweep("clr");

    // Random instruction stream
    for (int k = 0; k < 40; k++) begin
      rop = 4'($urandom_range(0, 15));
      if (rop == 4'hA) run_instr(enc_ldi($urandom_range(0, 7), 9'($urandom)));
      else if (rop == 4'h0 || rop > 4'hA) run_instr({rop, 12'($urandom)});
      else run_instr(enc(rop, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
    end
    for (int i = 0; i < 8; i++) check("final_reg", 32'(rf[i]), 32'(mdl[i]));

    // Reset asserted while the second operand is being read
    run_instr(enc_ldi(5, 9'h0A5));
    instr = enc(4'h2, 3, 1, 5);
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("readb_src", 32'(src), 32'(5 * 8));
    rst_n = 1'b0;
    #1;
    check("async_rst_src_din", {src, din}, 32'd0);
    check("async_rst_ctrl", {27'b0, sto, busy, done, ready, rf_rst}, 32'd0);
    check("async_rst_flags", {30'b0, fz, fc}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_held_no_sto", 32'(sto), 32'd0);
    end
    rst_n = 1'b1;
    mz = 1'b0;
    mc = 1'b0;
    check_sweep("mid_rst");
    run_instr(enc_ldi(1, 9'h100));
    run_instr(enc(4'h6, 2, 1, 1));          // XOR self: Z=1
    run_instr(enc(4'h5, 3, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
